// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder datapath: widths, exponent
// limits and the post-addition normalizer state encoding.
package fp_add_pkg;
    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int CNT_W  = 5;

    localparam logic [EXP_W-1:0] EXP_MAX       = 8'd255;
    localparam logic [EXP_W-1:0] EXP_OVF_LIMIT = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;
endpackage

// File: rtl/up_counter_5bit.sv
// Shift counter for the normalizer; the upward mirror of the alignment
// path's down-counter. Clear has priority over increment.
module up_counter_5bit #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc_en,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n)
            q <= '0;
        else if (clear)
            q <= '0;
        else if (inc_en)
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/fp_normalizer_seq.sv
// Sequential post-addition normalizer: one left shift per cycle until the
// hidden bit is set, with carry, zero, overflow and underflow handling.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Start; results and flags hold last values
//   NORM  | one normalization decision per cycle (zero/carry/ok/unf/shift)
//   DONE  | Done pulse; results valid; Start ignored
module fp_normalizer_seq #(
    parameter int MANT_W = fp_add_pkg::MANT_W,
    parameter int EXP_W  = fp_add_pkg::EXP_W,
    parameter int CNT_W  = fp_add_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [MANT_W+1:0] Mant_in,
    input  logic [EXP_W-1:0]  Exp_in,
    output logic [MANT_W-1:0] Mant_out,
    output logic [EXP_W-1:0]  Exp_out,
    output logic [CNT_W-1:0]  Shift_count,
    output logic              Busy,
    output logic              Done,
    output logic              Zero,
    output logic              Overflow,
    output logic              Underflow
);

    import fp_add_pkg::*;

    localparam int SIG_W = MANT_W + 2;

    norm_state_t       state, state_nxt;
    logic [SIG_W-1:0]  m, m_nxt;
    logic [EXP_W-1:0]  e, e_nxt;
    logic [MANT_W-1:0] mant_nxt;
    logic [EXP_W-1:0]  exp_nxt;
    logic              zero_nxt, ovf_nxt, unf_nxt;
    logic              busy_nxt, done_nxt;
    logic              cnt_clr, cnt_inc;

    up_counter_5bit #(.CNT_W(CNT_W)) u_shift_cnt (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .clear  (cnt_clr),
        .inc_en (cnt_inc),
        .q      (Shift_count)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            m         <= '0;
            e         <= '0;
            Mant_out  <= '0;
            Exp_out   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            state     <= state_nxt;
            m         <= m_nxt;
            e         <= e_nxt;
            Mant_out  <= mant_nxt;
            Exp_out   <= exp_nxt;
            Busy      <= busy_nxt;
            Done      <= done_nxt;
            Zero      <= zero_nxt;
            Overflow  <= ovf_nxt;
            Underflow <= unf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        e_nxt     = e;
        mant_nxt  = Mant_out;
        exp_nxt   = Exp_out;
        zero_nxt  = Zero;
        ovf_nxt   = Overflow;
        unf_nxt   = Underflow;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;

        case (state)
            IDLE: begin
                if (Start) begin
                    m_nxt     = Mant_in;
                    e_nxt     = Exp_in;
                    cnt_clr   = 1'b1;
                    zero_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = NORM;
                end
            end
            NORM: begin
                if (m == '0) begin
                    zero_nxt  = 1'b1;
                    exp_nxt   = '0;
                    mant_nxt  = '0;
                    state_nxt = DONE;
                end else if (m[SIG_W-1]) begin
                    if (e == EXP_OVF_LIMIT) begin
                        ovf_nxt   = 1'b1;
                        exp_nxt   = EXP_MAX;
                        mant_nxt  = '0;
                        state_nxt = DONE;
                    end else begin
                        m_nxt = m >> 1;
                        e_nxt = e + EXP_W'(1);
                    end
                end else if (m[MANT_W]) begin
                    mant_nxt  = m[MANT_W-1:0];
                    exp_nxt   = e;
                    state_nxt = DONE;
                end else if (e <= EXP_W'(1)) begin
                    // Minimum exponent reached: leave the fraction denormal.
                    unf_nxt   = 1'b1;
                    exp_nxt   = '0;
                    mant_nxt  = m[MANT_W-1:0];
                    state_nxt = DONE;
                end else begin
                    m_nxt   = m << 1;
                    e_nxt   = e - EXP_W'(1);
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: doc/fp_normalizer_seq.md
# fp_normalizer_seq

Sequential post-addition normalizer for the 32-bit floating-point adder datapath.
- Takes the raw 25-bit significand sum (carry, hidden bit, 23 fraction bits) and the pre-normalization exponent.
- Shifts left one position per cycle until the hidden bit is set, decrementing the exponent and counting shifts upward.
- Handles carry-out, zero, exponent overflow and exponent underflow.
- Sits between the significand adder and result packing. It is the counterpart of the alignment path's down-counter/right-shift loop.

## Interface
Parameters:
- MANT_W, 23, fraction width; internal significand is MANT_W+2 bits.
- EXP_W, 8, exponent width.
- CNT_W, 5, shift counter width; must hold MANT_W.

Ports:
- Clk  in  1  clock; all state changes on its rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Mant_in  in  25  raw sum: bit 24 carry, bit 23 hidden, bits 22:0 fraction.
- Exp_in  in  8  exponent before normalization.
- Mant_out  out  23  normalized fraction.
- Exp_out  out  8  normalized exponent.
- Shift_count  out  5  number of left shifts performed.
- Busy  out  1  high from the cycle after Start is accepted through the DONE state.
- Done  out  1  one-cycle pulse when results are valid.
- Zero  out  1  result is zero.
- Overflow  out  1  exponent reached 255; result is infinity.
- Underflow  out  1  normalization stopped at minimum exponent; result is denormal.

## Operation
States are IDLE, NORM and DONE. Internal registers:
- M: 25 bits.
- E: 8 bits.
- C: 5 bits.

IDLE
- Busy=0.
- When Start=1: load M←Mant_in, E←Exp_in, C←0; go to NORM.
- Result outputs hold their last values.

NORM: one decision per cycle, in this priority order.
1. M==0: Zero=1, Exp_out=0, Mant_out=0 → DONE.
2. M[24]=1 (carry):
   - If E==254: Overflow=1, Exp_out=255, Mant_out=0 → DONE.
   - Otherwise: M←M>>1, E←E+1; stay in NORM.
3. M[23]=1: Mant_out=M[22:0], Exp_out=E, Shift_count=C → DONE.
4. E≤1: Underflow=1, Exp_out=0, Mant_out=M[22:0] (unshifted further), Shift_count=C → DONE.
5. Otherwise: M←M<<1, E←E−1, C←C+1; stay in NORM.

DONE
- Done=1 for exactly one cycle.
- Go to IDLE.
- Flags and results stay registered until the next accepted Start. Each accepted Start clears all flags.

Arithmetic
- All exponent arithmetic is unsigned 8-bit. Branch ordering guarantees no wrap: no increment at 254, no decrement at ≤1.
- Left shifts per operation ≤ 23, so C never wraps.
- Carry and left shift are mutually exclusive within one operation.

Start rules
- Start while Busy=1 is ignored.
- Start in the DONE cycle is ignored. A new Start is accepted the cycle after Done.

## Timing
- Reset (Rst_n=0 at an edge) gives state IDLE and all outputs 0: Mant_out, Exp_out, Shift_count, Busy, Done, Zero, Overflow, Underflow.
- Reset mid-operation aborts immediately. No Done is issued.
- Latency, counted from the Start edge to Done high:
  - Already normalized: 2 cycles.
  - k left shifts: 2+k cycles. Worst case k=23 gives 25 cycles.
  - Carry: 3 cycles.
  - Zero or overflow: 2 cycles.
- Results are valid in the Done cycle and stable afterwards until the next Start.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

## Structure
- Shared package fp_add_pkg:
  - MANT_W, EXP_W, CNT_W.
  - EXP_MAX=255, EXP_OVF_LIMIT=254.
  - State enum norm_state_t {IDLE, NORM, DONE}.
- One sub-module: up_counter_5bit, with clear, increment enable and Q. It is the upward mirror of the alignment down-counter and drives C/Shift_count.
- The shift register and exponent update live in the top module.

## Test plan
- Mant_in=25'h0800000, Exp_in=8'd127, Start → Done at cycle 2; Mant_out=0, Exp_out=127, Shift_count=0, no flags.
- Mant_in=25'h0010000 (bit 16), Exp_in=8'd100 → Done at cycle 9; Exp_out=93, Shift_count=7, Mant_out=0.
- Mant_in=25'h1800000, Exp_in=8'd127 → Done at cycle 3; Exp_out=128, Mant_out=23'h400000, Shift_count=0.
- Mant_in=25'h1000000, Exp_in=8'd254 → Overflow=1, Exp_out=255, Mant_out=0. Mant_in=0 → Zero=1, Exp_out=0, Done at cycle 2.
- Mant_in=25'h0000100, Exp_in=8'd5 → 4 shifts, then Underflow=1, Exp_out=0, Mant_out=23'h001000, Shift_count=4.
- Start with a 10-shift case, Rst_n=0 at cycle 4 → all outputs 0 the next cycle and no Done. Second Start while Busy=1 → ignored; the original result completes unchanged.
